// File: rtl/lcd_timing_pkg.sv
// Shared types and constants for the LCD timing controller.
package lcd_timing_pkg;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    BP     = 2'd1,
    ACTIVE = 2'd2,
    FP     = 2'd3
  } axis_state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_COLOR  = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_LINE   = 2'd3;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_IRQ_EN  = 1;
  localparam int unsigned CTRL_TESTPAT = 2;

  localparam int unsigned STAT_DONE   = 0;
  localparam int unsigned STAT_VBLANK = 1;

  // Counter width able to hold 0..(longest segment - 1); never below 1 bit.
  function automatic int unsigned seg_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/lcd_timing_ctrl_if.sv
// Avalon-MM register port of the LCD timing controller.
interface lcd_timing_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, output chipselect, output write_n, output writedata,
                  input readdata);
  modport slave  (input address, input chipselect, input write_n, input writedata,
                  output readdata);
endinterface

// File: rtl/lcd_axis_counter.sv
// One timing axis: walks SYNC -> BP -> ACTIVE -> FP, each segment lasting its length.
module lcd_axis_counter
  import lcd_timing_pkg::*;
#(
  parameter int unsigned SYNC_LEN = 1,
  parameter int unsigned BP_LEN   = 1,
  parameter int unsigned ACT_LEN  = 1,
  parameter int unsigned FP_LEN   = 1,
  parameter int unsigned CW       = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear_i,
  input  logic          adv_i,
  output axis_state_e   state_o,
  output logic [CW-1:0] count_o,
  output logic          last_o,
  output logic          wrap_o
);

  axis_state_e   state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] seg_last;

  // State register; reset and clear both park the axis at SYNC/0
  always_ff @(posedge clk) begin
    if (!reset_n || clear_i) begin
      state_q <= SYNC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next state: count within the segment, step to the next segment on its last count
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (adv_i) begin
      if (last_o) begin
        count_d = '0;
        case (state_q)
          SYNC:    state_d = BP;
          BP:      state_d = ACTIVE;
          ACTIVE:  state_d = FP;
          default: state_d = SYNC;
        endcase
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Outputs: last count of current segment, and FP->SYNC wrap strobe
  always_comb begin
    case (state_q)
      SYNC:    seg_last = CW'(SYNC_LEN - 1);
      BP:      seg_last = CW'(BP_LEN - 1);
      ACTIVE:  seg_last = CW'(ACT_LEN - 1);
      default: seg_last = CW'(FP_LEN - 1);
    endcase
    last_o = (count_q == seg_last);
    wrap_o = adv_i && last_o && (state_q == FP);
  end

  assign state_o = state_q;
  assign count_o = count_q;

endmodule

// File: rtl/lcd_timing_ctrl.sv
// RGB LCD timing controller with Avalon-MM register file and frame-done interrupt.
// Optional feature macro: LCD_TESTPAT_EN (CTRL[2] selects colour bars from pixel index).
module lcd_timing_ctrl
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 480,
  parameter int unsigned H_FP     = 2,
  parameter int unsigned H_SYNC   = 41,
  parameter int unsigned H_BP     = 2,
  parameter int unsigned V_ACTIVE = 272,
  parameter int unsigned V_FP     = 2,
  parameter int unsigned V_SYNC   = 10,
  parameter int unsigned V_BP     = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  lcd_timing_ctrl_if.slave   bus,
  output logic               lcd_hsync,
  output logic               lcd_vsync,
  output logic               lcd_de,
  output logic [4:0]         lcd_r,
  output logic [5:0]         lcd_g,
  output logic [4:0]         lcd_b,
  output logic               irq
);

  localparam int unsigned HW = seg_width(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VW = seg_width(V_ACTIVE, V_FP, V_SYNC, V_BP);

`ifdef LCD_TESTPAT_EN
  localparam logic [2:0] CTRL_MASK = 3'b111;
`else
  localparam logic [2:0] CTRL_MASK = 3'b011;
`endif

  logic [2:0]  ctrl_q, ctrl_d;
  logic [15:0] color_q, color_d;
  logic [15:0] live_q, live_d;
  logic        done_q, done_d;

  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic [15:0] rgb_q, rgb_d;

  logic        en, wr;
  axis_state_e h_state, v_state;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic        h_last, h_wrap, v_last, v_wrap_unused;
  logic        frame_start, done_set;
  logic [15:0] pix_rgb;
  logic        unused_bits;

  assign en = ctrl_q[CTRL_EN];
  assign wr = bus.chipselect && !bus.write_n;

  lcd_axis_counter #(
    .SYNC_LEN (H_SYNC),
    .BP_LEN   (H_BP),
    .ACT_LEN  (H_ACTIVE),
    .FP_LEN   (H_FP),
    .CW       (HW)
  ) u_h_axis (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (!en),
    .adv_i   (en),
    .state_o (h_state),
    .count_o (h_cnt),
    .last_o  (h_last),
    .wrap_o  (h_wrap)
  );

  lcd_axis_counter #(
    .SYNC_LEN (V_SYNC),
    .BP_LEN   (V_BP),
    .ACT_LEN  (V_ACTIVE),
    .FP_LEN   (V_FP),
    .CW       (VW)
  ) u_v_axis (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (!en),
    .adv_i   (h_wrap),
    .state_o (v_state),
    .count_o (v_cnt),
    .last_o  (v_last),
    .wrap_o  (v_wrap_unused)
  );

  assign frame_start = en && (h_state == SYNC) && (h_cnt == '0)
                          && (v_state == SYNC) && (v_cnt == '0);
  assign done_set    = h_wrap && (v_state == ACTIVE) && v_last;

`ifdef LCD_TESTPAT_EN
  logic [2:0] pix;
  // Active pixel colour: bars from pixel index when test pattern selected
  always_comb begin
    pix     = 3'(h_cnt);
    pix_rgb = ctrl_q[CTRL_TESTPAT] ? {{5{pix[0]}}, {6{pix[1]}}, {5{pix[2]}}} : live_q;
  end
  assign unused_bits = ^{bus.writedata[31:16], h_last, v_wrap_unused};
`else
  assign pix_rgb     = live_q;
  assign unused_bits = ^{bus.writedata[31:16], h_last, v_wrap_unused, ctrl_q[CTRL_TESTPAT]};
`endif

  // Register file next state; frame_done set beats a same-cycle write-1-clear
  always_comb begin
    ctrl_d  = ctrl_q;
    color_d = color_q;
    live_d  = live_q;
    done_d  = done_q;
    if (wr && bus.address == ADDR_CTRL)  ctrl_d  = bus.writedata[2:0] & CTRL_MASK;
    if (wr && bus.address == ADDR_COLOR) color_d = bus.writedata[15:0];
    if (frame_start)                     live_d  = color_q;
    if (done_set)
      done_d = 1'b1;
    else if (wr && bus.address == ADDR_STATUS && bus.writedata[STAT_DONE])
      done_d = 1'b0;
  end

  // Register file state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_q  <= '0;
      color_q <= '0;
      live_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      color_q <= color_d;
      live_q  <= live_d;
      done_q  <= done_d;
    end
  end

  // Video outputs decoded from axis state; idle values while disabled
  always_comb begin
    hsync_d = 1'b1;
    vsync_d = 1'b1;
    de_d    = 1'b0;
    rgb_d   = '0;
    if (en) begin
      hsync_d = (h_state != SYNC);
      vsync_d = (v_state != SYNC);
      de_d    = (h_state == ACTIVE) && (v_state == ACTIVE);
      if (de_d) rgb_d = pix_rgb;
    end
  end

  // Video output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      rgb_q   <= rgb_d;
    end
  end

  // Read mux, combinational on address
  always_comb begin
    case (bus.address)
      ADDR_CTRL:   bus.readdata = {29'b0, ctrl_q};
      ADDR_COLOR:  bus.readdata = {16'b0, color_q};
      ADDR_STATUS: bus.readdata = {30'b0, en && (v_state != ACTIVE), done_q};
      default:     bus.readdata = {16'b0, 16'(v_cnt)};
    endcase
  end

  assign lcd_hsync = hsync_q;
  assign lcd_vsync = vsync_q;
  assign lcd_de    = de_q;
  assign lcd_r     = rgb_q[15:11];
  assign lcd_g     = rgb_q[10:5];
  assign lcd_b     = rgb_q[4:0];
  assign irq       = done_q && ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// Randomized bench for lcd_timing_ctrl against a frame-position reference model.
// Honours LCD_TESTPAT_EN the same way as the design.
module tb_lcd_timing_ctrl;

  localparam int unsigned HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int unsigned VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned FT = HT * VT;

`ifdef LCD_TESTPAT_EN
  localparam logic [2:0] MASK = 3'b111;
`else
  localparam logic [2:0] MASK = 3'b011;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       lcd_hsync, lcd_vsync, lcd_de, irq;
  logic [4:0] lcd_r, lcd_b;
  logic [5:0] lcd_g;

  lcd_timing_ctrl_if bus_if ();

  lcd_timing_ctrl #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus_if),
    .lcd_hsync (lcd_hsync),
    .lcd_vsync (lcd_vsync),
    .lcd_de    (lcd_de),
    .lcd_r     (lcd_r),
    .lcd_g     (lcd_g),
    .lcd_b     (lcd_b),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: position within the frame plus register contents
  int unsigned m_pos = 0;
  logic [2:0]  m_ctrl = '0;
  logic [15:0] m_color = '0, m_live = '0, m_rgb = '0;
  logic        m_done = 1'b0, m_hs = 1'b1, m_vs = 1'b1, m_de = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Segment of a position along one axis: 0 sync, 1 back porch, 2 active, 3 front porch
  function automatic int unsigned seg(input int unsigned x, input int unsigned s,
                                      input int unsigned b, input int unsigned a);
    if (x < s) return 0;
    if (x < s + b) return 1;
    if (x < s + b + a) return 2;
    return 3;
  endfunction

  function automatic int unsigned seg_cnt(input int unsigned x, input int unsigned s,
                                          input int unsigned b, input int unsigned a);
    case (seg(x, s, b, a))
      0:       return x;
      1:       return x - s;
      2:       return x - s - b;
      default: return x - s - b - a;
    endcase
  endfunction

  function automatic logic [15:0] bars(input int unsigned p);
    logic [2:0] pb;
    pb = 3'(p);
    return {{5{pb[0]}}, {6{pb[1]}}, {5{pb[2]}}};
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    int unsigned l;
    l = m_pos / HT;
    case (a)
      2'd0:    return {29'b0, m_ctrl};
      2'd1:    return {16'b0, m_color};
      2'd2:    return {30'b0, m_ctrl[0] && (seg(l, VS, VB, VA) != 2), m_done};
      default: return 32'(seg_cnt(l, VS, VB, VA));
    endcase
  endfunction

  task automatic model_edge();
    logic        wr, set;
    int unsigned hp, l;
    wr  = bus_if.chipselect && !bus_if.write_n;
    set = 1'b0;
    if (!reset_n) begin
      m_pos = 0; m_ctrl = '0; m_color = '0; m_live = '0; m_done = 1'b0;
      m_hs = 1'b1; m_vs = 1'b1; m_de = 1'b0; m_rgb = '0;
    end else begin
      if (m_ctrl[0]) begin
        hp    = m_pos % HT;
        l     = m_pos / HT;
        m_hs  = seg(hp, HS, HB, HA) != 0;
        m_vs  = seg(l, VS, VB, VA) != 0;
        m_de  = (seg(hp, HS, HB, HA) == 2) && (seg(l, VS, VB, VA) == 2);
        m_rgb = '0;
        if (m_de) m_rgb = m_ctrl[2] ? bars(hp - HS - HB) : m_live;
        set   = (hp == HT - 1) && (l == VS + VB + VA - 1);
        if (m_pos == 0) m_live = m_color;
        m_pos = (m_pos + 1) % FT;
      end else begin
        m_hs = 1'b1; m_vs = 1'b1; m_de = 1'b0; m_rgb = '0; m_pos = 0;
      end
      if (wr && bus_if.address == 2'd0) m_ctrl  = bus_if.writedata[2:0] & MASK;
      if (wr && bus_if.address == 2'd1) m_color = bus_if.writedata[15:0];
      if (set) m_done = 1'b1;
      else if (wr && bus_if.address == 2'd2 && bus_if.writedata[0]) m_done = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("hsync", 32'(lcd_hsync), 32'(m_hs));
    check("vsync", 32'(lcd_vsync), 32'(m_vs));
    check("de", 32'(lcd_de), 32'(m_de));
    check("rgb", 32'({lcd_r, lcd_g, lcd_b}), 32'(m_rgb));
    check("irq", 32'(irq), 32'(m_done && m_ctrl[1]));
    check("readdata", bus_if.readdata, m_read(bus_if.address));
  endtask

  task automatic idle();
    bus_if.chipselect = 1'($urandom);
    bus_if.write_n    = 1'b1;
    bus_if.address    = 2'($urandom);
    bus_if.writedata  = $urandom;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    bus_if.address    = a;
    bus_if.writedata  = d;
    step();
    idle();
  endtask

  task automatic run(input int unsigned n);
    repeat (n) begin
      step();
      idle();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    int unsigned r;
    logic [31:0] d;

    reset_n = 1'b0;
    idle();
    step();
    reset_n = 1'b1;
    for (int unsigned a = 0; a < 4; a++) begin
      bus_if.address = 2'(a);
      #1;
      check("reset_read", bus_if.readdata, 32'h0);
    end
    idle();

    wr(2'd1, 32'h0000_F81F);
    wr(2'd0, 32'h0000_0001);
    run(2 * FT);

    run(20);
    wr(2'd1, 32'h0000_07E0);
    run(2 * FT);

    wr(2'd0, 32'h0000_0003);
    run(FT);
    wr(2'd2, 32'h0000_0001);
    run(5);

    // Clear requested on the very edge where frame_done is set
    found = 1'b0;
    for (int unsigned i = 0; i < 2 * FT; i++) begin
      if (m_ctrl[0] && m_pos == (VS + VB + VA) * HT - 1) begin
        found = 1'b1;
        break;
      end
      step();
      idle();
    end
    if (!found) check("find_set_cycle", 32'd0, 32'd1);
    else begin
      wr(2'd2, 32'h0000_0001);
      check("irq_set_wins", 32'(irq), 32'd1);
    end
    run(FT);

    wr(2'd0, 32'h0000_0005);
    run(2 * FT);
    wr(2'd0, 32'h0000_0001);

    // Disable mid-line then re-enable
    for (int unsigned i = 0; i < HT && (m_pos % HT) != 5; i++) begin
      step();
      idle();
    end
    wr(2'd0, 32'h0000_0000);
    run(5);
    wr(2'd0, 32'h0000_0001);
    run(FT + 4);

    for (int unsigned i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 299);
      d = $urandom;
      if (r < 9) begin
        if ($urandom_range(0, 4) != 0) d[0] = 1'b1;
        wr(2'd0, d);
      end else if (r < 24) begin
        wr(2'd1, d);
      end else if (r < 33) begin
        wr(2'd2, d);
      end else if (r < 39) begin
        wr(2'd3, d);
      end else if (r == 299) begin
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        idle();
        wr(2'd0, 32'h0000_0007);
      end else begin
        step();
        idle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
